multicycle_control: RTL and testbench

Main sequencing FSM for the multi-cycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and steps the datapath through fetch, decode, execute, memory and write-back. Each cycle it drives the datapath enables, the multiplexer selects and the 3-bit `alu_op` consumed by `ALUcontrol`. Memory accesses stall on a ready handshake; unsupported opcodes trap into a sticky error state.

---
 rtl/multicycle_control_pkg.sv | 62 ++++++
 rtl/multicycle_control_out_decode.sv | 92 +++++++++
 rtl/multicycle_control.sv | 103 ++++++++++
 tb/tb_multicycle_control.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALU op codes,
// mux selects, FSM state numbering and the bundle of datapath control outputs.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_SLT   = 3'b010;
    localparam logic [2:0] ALUOP_ADD   = 3'b011;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTEXEC  = 4'd7,
        S_RTWB    = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_BEQEXEC = 4'd11,
        S_JEXEC   = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_out_decode.sv
// Combinational output decode: maps (state, opcode, mem_ready) to datapath controls.
// Only the FETCH write enables and the MEMWR retire pulse look at mem_ready.
module control_out_decode
    import multicycle_control_pkg::*;
#(
    parameter int OPW = 6
) (
    input  state_t           state,
    input  logic [OPW-1:0]   opcode,
    input  logic             mem_ready,
    output ctrl_t            ctrl
);

    logic is_slti;

    assign is_slti = (opcode == OPW'(OP_SLTI));

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_RTEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_RTWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.alu_op     = ALUOP_RTYPE;
                ctrl.instr_done = 1'b1;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = is_slti ? ALUOP_SLT : ALUOP_ADD;
            end
            S_IWB: begin
                // IR only loads in FETCH, so the opcode still selects the same ALU op here
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = is_slti ? ALUOP_SLT : ALUOP_ADD;
                ctrl.instr_done = 1'b1;
            end
            S_BEQEXEC: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JEXEC: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multi-cycle MIPS datapath. Holds the state register
// and next-state logic; all outputs come from control_out_decode.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           i_or_d,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           mem_to_reg,
    output logic           reg_dst,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     pc_source,
    output logic [2:0]     alu_op,
    output logic           instr_done,
    output logic           illegal_op,
    output logic [3:0]     state_o
);

    state_t state, state_nxt;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:  state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) begin
                    state_nxt = S_MEMADR;
                end else if (opcode == OPW'(OP_RTYPE)) begin
                    state_nxt = S_RTEXEC;
                end else if (opcode == OPW'(OP_ADDI) || opcode == OPW'(OP_SLTI)) begin
                    state_nxt = S_IEXEC;
                end else if (opcode == OPW'(OP_BEQ)) begin
                    state_nxt = S_BEQEXEC;
                end else if (opcode == OPW'(OP_J)) begin
                    state_nxt = S_JEXEC;
                end else begin
                    state_nxt = S_TRAP;
                end
            end
            S_MEMADR:  state_nxt = (opcode == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:   state_nxt = S_FETCH;
            S_MEMWR:   if (mem_ready) state_nxt = S_FETCH;
            S_RTEXEC:  state_nxt = S_RTWB;
            S_RTWB:    state_nxt = S_FETCH;
            S_IEXEC:   state_nxt = S_IWB;
            S_IWB:     state_nxt = S_FETCH;
            S_BEQEXEC: state_nxt = S_FETCH;
            S_JEXEC:   state_nxt = S_FETCH;
            // TRAP is only left through rst
            S_TRAP:    state_nxt = S_TRAP;
            default:   state_nxt = S_RESET;
        endcase
    end

    control_out_decode #(
        .OPW (OPW)
    ) u_decode (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;
    assign state_o       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences with memory stalls,
// trap behaviour and asynchronous reset, all against hand-computed expectations.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;
    int trace[$];

    multicycle_control #(.OPW(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] ctrl_vec();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                instr_done, alu_op == 3'b011 ? 1'b0 : 1'b1};
    endfunction

    // Entered at a negedge with the FSM in FETCH; returns at the next FETCH negedge.
    task automatic run_instr(input string tag, input logic [5:0] op, input int stall_st,
                             input int nstall, input int exp_lat);
        int stalls = 0;
        int pw_cnt = 0;
        int lat = 0;
        bit done = 0;
        logic [2:0] iop;
        iop = (op == 6'h0A) ? 3'b010 : 3'b011;
        opcode = op;
        trace.delete();
        for (int i = 0; i < 20 && !done; i++) begin
            lat++;
            trace.push_back(int'(state_o));
            if (int'(state_o) == stall_st && stalls < nstall) begin
                mem_ready = 1'b0;
                stalls++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            case (state_o)
                4'd1: begin
                    chk({tag, "_fetch_pcw"}, pc_write, mem_ready);
                    chk({tag, "_fetch_irw"}, ir_write, mem_ready);
                    chk({tag, "_fetch_rd"}, {mem_read, i_or_d, alu_src_b}, 4'b1001);
                    if (pc_write && ir_write) pw_cnt++;
                end
                4'd4: chk({tag, "_memrd"}, {i_or_d, mem_read}, 2'b11);
                4'd5: chk({tag, "_memwb"}, {mem_to_reg, reg_write, reg_dst}, 3'b110);
                4'd6: chk({tag, "_memwr"}, {mem_write, i_or_d, instr_done}, {2'b11, mem_ready});
                4'd7: chk({tag, "_rtexec_aluop"}, alu_op, 3'b000);
                4'd8: chk({tag, "_rtwb"}, {alu_op, reg_dst, reg_write}, 5'b000_1_1);
                4'd9: chk({tag, "_iexec_aluop"}, alu_op, iop);
                4'd10: chk({tag, "_iwb"}, {alu_op, reg_write, reg_dst}, {iop, 2'b10});
                4'd11: chk({tag, "_beq"}, {alu_op, pc_write_cond, pc_source, reg_write},
                           {3'b001, 1'b1, 2'b01, 1'b0});
                4'd12: chk({tag, "_j"}, {pc_write, pc_source}, 3'b1_10);
                default: ;
            endcase
            if (instr_done) done = 1;
            @(negedge clk);
        end
        chk({tag, "_retired"}, done, 1'b1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_pcw_once"}, pw_cnt, 1);
        chk({tag, "_back_to_fetch"}, state_o, 4'd1);
    endtask

    initial begin
        int rt_exp[4] = '{1, 2, 7, 8};
        int hit;

        // reset state
        #3 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_state", state_o, 4'd0);
        chk("rst_ctrls", ctrl_vec(), 18'd0);
        chk("rst_aluop", alu_op, 3'b011);
        chk("rst_illegal", illegal_op, 1'b0);
        rst = 1'b0;
        #1 chk("rel_state", state_o, 4'd0);
        @(negedge clk);
        chk("first_fetch", state_o, 4'd1);

        // R-type: 1,2,7,8 then back to 1
        run_instr("rtype", 6'h00, -1, 0, 4);
        chk("rt_trace_len", trace.size(), 4);
        foreach (rt_exp[k]) begin
            hit = (k < trace.size()) ? trace[k] : -1;
            chk("rt_trace", hit, rt_exp[k]);
        end

        run_instr("lw_stall", 6'h23, 4, 2, 7);
        run_instr("fetch_stall", 6'h08, 1, 3, 7);
        run_instr("slti", 6'h0A, -1, 0, 4);
        run_instr("beq", 6'h04, -1, 0, 3);
        run_instr("sw", 6'h2B, 6, 1, 5);
        run_instr("j", 6'h02, -1, 0, 3);
        run_instr("lw", 6'h23, -1, 0, 5);

        // illegal opcode traps
        opcode = 6'h3F;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("trap_decode", state_o, 4'd2);
        @(negedge clk);
        chk("trap_enter", state_o, 4'd13);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            chk("trap_illegal", illegal_op, 1'b1);
            chk("trap_ctrls", ctrl_vec(), 18'd0);
            chk("trap_state", state_o, 4'd13);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("trap_clr_illegal", illegal_op, 1'b0);
        chk("trap_clr_state", state_o, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'h2B;
        @(negedge clk);
        chk("sw2_fetch", state_o, 4'd1);

        // async reset during a stalled store
        @(negedge clk);
        @(negedge clk);
        chk("sw2_memadr", state_o, 4'd3);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("sw2_memwr", state_o, 4'd6);
        chk("sw2_mem_write", mem_write, 1'b1);
        chk("sw2_no_done", instr_done, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_mem_write", mem_write, 1'b0);
        chk("arst_state", state_o, 4'd0);
        chk("arst_ctrls", ctrl_vec(), 18'd0);
        @(negedge clk);
        chk("arst_hold_wr", {mem_write, reg_write}, 2'b00);
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("arst_refetch", state_o, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
